// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN image path.
//   IMG_PIXELS / IMG_BYTES : frame geometry (1-bit pixels packed 8 per byte)
//   RESULT_W               : width of the classification result
//   imgbuf_state_t         : state encoding of the image buffer controller
package bnn_pkg;

    localparam int IMG_PIXELS = 784;
    localparam int IMG_BYTES  = IMG_PIXELS / 8;
    localparam int RESULT_W   = 4;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        DONE = 2'd2
    } imgbuf_state_t;

endpackage

// File: rtl/img_buffer_ctrl.sv
// Image buffer controller: producer side of the BNN image handshake.
// Assembles a frame of packed 1-bit pixels from a byte stream, presents it to
// the inference core, captures the classification result, then re-arms.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_byte/valid     packed pixel byte (bit 7 = lowest-index pixel)
//   rx_ready          byte accepted this cycle when rx_valid is also high
//   clear             synchronous abort: drop frame and result, back to FILL
//   img_out           assembled frame, [0:IMG_PIXELS-1]
//   img_buffer_full   frame complete, inference requested
//   result_ready/in   result flag (level, edge-detected) and value from core
//   result_out/valid  latched result and its freshness flag
//   timeout_err       sticky: no result arrived within TIMEOUT_CYCLES
//   byte_count        bytes accepted into the current frame
//
// Byte handshake: a byte transfers on a rising clk edge where rx_valid and
// rx_ready are both high. While rx_ready is low the sender must hold rx_byte
// and rx_valid stable; nothing is consumed. A byte that transfers in the same
// cycle as clear is dropped.
module img_buffer_ctrl #(
    parameter int IMG_PIXELS     = bnn_pkg::IMG_PIXELS,
    parameter int RESULT_W       = bnn_pkg::RESULT_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [7:0]                           rx_byte,
    input  logic                                 rx_valid,
    output logic                                 rx_ready,
    input  logic                                 clear,
    output logic                                 img_out [0:IMG_PIXELS-1],
    output logic                                 img_buffer_full,
    input  logic                                 result_ready,
    input  logic [RESULT_W-1:0]                  result_in,
    output logic [RESULT_W-1:0]                  result_out,
    output logic                                 result_valid,
    output logic                                 timeout_err,
    output logic [$clog2(IMG_PIXELS/8+1)-1:0]    byte_count
);
    import bnn_pkg::*;

    localparam int NBYTES = IMG_PIXELS / 8;
    localparam int BCW    = $clog2(NBYTES + 1);
    localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

    if (IMG_PIXELS % 8 != 0) begin : g_bad_size
        $error("img_buffer_ctrl: IMG_PIXELS (%0d) must be a multiple of 8", IMG_PIXELS);
    end

    imgbuf_state_t         state_q, state_d;
    logic [0:IMG_PIXELS-1] img_q;       // ascending so a byte slice maps MSB to lowest pixel
    logic                  rr_q;        // result_ready one cycle ago, tracked in every state
    logic [TW-1:0]         tmo_cnt;
    logic                  ready_q;
    logic                  full_q;
    logic                  accept;
    logic                  last_byte;
    logic                  rise;
    logic                  tmo_hit;

    assign rx_ready        = ready_q;
    assign img_buffer_full = full_q;

    assign accept    = (state_q == FILL) && rx_valid && ready_q && !clear;
    assign last_byte = accept && (byte_count == LAST_BYTE);
    // A level left high by the previous frame is not an edge; the core must
    // drop and re-raise result_ready.
    assign rise      = result_ready && !rr_q;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        for (int p = 0; p < IMG_PIXELS; p++) begin
            img_out[p] = img_q[p];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (last_byte) state_d = FULL;
            FULL: begin
                if (rise)         state_d = DONE;
                else if (tmo_hit) state_d = FILL;
            end
            DONE:    state_d = FILL;
            default: state_d = FILL;
        endcase
        if (clear) state_d = FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q        <= '0;
            byte_count   <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            tmo_cnt      <= '0;
            rr_q         <= 1'b0;
            ready_q      <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            rr_q    <= result_ready;
            // rx_ready is registered so it stays low through the reset cycle.
            ready_q <= (state_d == FILL);
            // Raised one cycle into FULL; dropped on the edge that leaves FULL.
            full_q  <= (state_q == FULL) && (state_d == FULL);
            if (clear) begin
                img_q        <= '0;
                byte_count   <= '0;
                result_valid <= 1'b0;
                timeout_err  <= 1'b0;
                tmo_cnt      <= '0;
            end else begin
                case (state_q)
                    FILL: begin
                        tmo_cnt <= '0;
                        if (accept) begin
                            img_q[int'(byte_count)*8 +: 8] <= rx_byte;
                            byte_count <= byte_count + 1'b1;
                            if (byte_count == '0) begin
                                result_valid <= 1'b0;
                                timeout_err  <= 1'b0;
                            end
                        end
                    end
                    FULL: begin
                        if (rise) begin
                            result_out   <= result_in;
                            result_valid <= 1'b1;
                        end else if (tmo_hit) begin
                            timeout_err <= 1'b1;
                            img_q       <= '0;
                            byte_count  <= '0;
                            tmo_cnt     <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        img_q      <= '0;
                        byte_count <= '0;
                        tmo_cnt    <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
